treasure_classifier: RTL

Per-frame colour and shape classifier fed directly by the camera down-sampler's pixel stream (RGB332 pixel, X/Y address, write enable) on the camera pixel clock. It counts red and blue pixels over the whole frame and measures red/blue run widths on three sampling rows. At each vsync rising edge it decides the treasure colour and shape. The result is registered and held for the Arduino interface until the next frame's decision.

---
 rtl/treasure_classifier_if.sv | 22 ++
 rtl/treasure_classifier.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/treasure_classifier_if.sv
// Camera pixel stream into the classifier and the per-frame result back out.
interface treasure_classifier_if;
    logic        vsync;
    logic        pixel_valid;
    logic [7:0]  pixel;
    logic [14:0] x_addr;
    logic [14:0] y_addr;
    logic [1:0]  COLOR;
    logic [1:0]  SHAPE;
    logic        RESULT_VALID;
    logic [15:0] RED_COUNT;
    logic [15:0] BLUE_COUNT;

    modport master (
        output vsync, pixel_valid, pixel, x_addr, y_addr,
        input  COLOR, SHAPE, RESULT_VALID, RED_COUNT, BLUE_COUNT
    );
    modport slave (
        input  vsync, pixel_valid, pixel, x_addr, y_addr,
        output COLOR, SHAPE, RESULT_VALID, RED_COUNT, BLUE_COUNT
    );
endinterface

// File: rtl/treasure_classifier.sv
// Per-frame red/blue colour and shape classifier; decides at each vsync rise
// and holds the result for the host until the next decision.
module treasure_classifier #(
    parameter int SCREEN_W   = 176,
    parameter int SCREEN_H   = 144,
    parameter int TOP_ROW    = 36,
    parameter int MID_ROW    = 72,
    parameter int BOT_ROW    = 108,
    parameter int MIN_PIXELS = 200,
    parameter int MARGIN     = 8
) (
    input  logic                  pclk,
    input  logic                  reset,
    treasure_classifier_if.slave  cam
);
    typedef enum logic [1:0] {ACCUM, DECIDE_COLOR, DECIDE_SHAPE, PUBLISH} state_t;

    state_t      state_q, state_d;
    logic        vsync_q;
    logic [15:0] red_acc_q, blue_acc_q;
    logic [2:0][7:0] red_w_q, blue_w_q;
    logic [1:0]  win_q, win_d;
    logic [7:0]  wt_q, wm_q, wb_q;
    logic [1:0]  color_q, shape_q, shape_d;
    logic        valid_q;
    logic [15:0] red_cnt_q, blue_cnt_q;

    logic       eof, accept, is_red, is_blue;
    logic [2:0] band_hit;
    logic [8:0] t9, m9, b9, d_tm, d_bm;

    assign eof     = cam.vsync && !vsync_q;
    assign accept  = cam.pixel_valid && (state_q == ACCUM) &&
                     (cam.x_addr < 15'(SCREEN_W)) && (cam.y_addr < 15'(SCREEN_H));
    assign is_red  = (cam.pixel[7:5] >= 3'd4) && (cam.pixel[4:2] < 3'd4) && (cam.pixel[1:0] < 2'd2);
    assign is_blue = (cam.pixel[1:0] >= 2'd2) && (cam.pixel[7:5] < 3'd4) && (cam.pixel[4:2] < 3'd4);
    assign band_hit = {cam.y_addr == 15'(BOT_ROW), cam.y_addr == 15'(MID_ROW),
                       cam.y_addr == 15'(TOP_ROW)};

    always_ff @(posedge pclk) begin
        if (reset) state_q <= ACCUM;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM:        if (eof) state_d = DECIDE_COLOR;
            DECIDE_COLOR: state_d = DECIDE_SHAPE;
            DECIDE_SHAPE: state_d = PUBLISH;
            default:      state_d = ACCUM;
        endcase
    end

    // Ties and sub-threshold frames classify as no colour.
    always_comb begin
        win_d = 2'd0;
        if (red_acc_q > blue_acc_q && red_acc_q >= 16'(MIN_PIXELS))
            win_d = 2'd1;
        else if (blue_acc_q > red_acc_q && blue_acc_q >= 16'(MIN_PIXELS))
            win_d = 2'd2;
    end

    assign t9   = {1'b0, wt_q};
    assign m9   = {1'b0, wm_q};
    assign b9   = {1'b0, wb_q};
    assign d_tm = (t9 > m9) ? t9 - m9 : m9 - t9;
    assign d_bm = (b9 > m9) ? b9 - m9 : m9 - b9;

    always_comb begin
        shape_d = 2'd0;
        if (win_q != 2'd0) begin
            if (d_tm <= 9'(MARGIN) && d_bm <= 9'(MARGIN))
                shape_d = 2'd2;
            else if (m9 > t9 + 9'(MARGIN) && b9 > m9 + 9'(MARGIN))
                shape_d = 2'd1;
            else if (m9 > t9 + 9'(MARGIN) && m9 > b9 + 9'(MARGIN))
                shape_d = 2'd3;
        end
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            vsync_q    <= 1'b1;
            red_acc_q  <= '0;
            blue_acc_q <= '0;
            red_w_q    <= '0;
            blue_w_q   <= '0;
            win_q      <= '0;
            wt_q       <= '0;
            wm_q       <= '0;
            wb_q       <= '0;
            color_q    <= '0;
            shape_q    <= '0;
            valid_q    <= 1'b0;
            red_cnt_q  <= '0;
            blue_cnt_q <= '0;
        end else begin
            vsync_q <= cam.vsync;
            case (state_q)
                ACCUM: if (accept) begin
                    if (is_red && red_acc_q != 16'hFFFF)   red_acc_q  <= red_acc_q + 16'd1;
                    if (is_blue && blue_acc_q != 16'hFFFF) blue_acc_q <= blue_acc_q + 16'd1;
                    for (int k = 0; k < 3; k++) begin
                        if (band_hit[k] && is_red && red_w_q[k] != 8'hFF)
                            red_w_q[k] <= red_w_q[k] + 8'd1;
                        if (band_hit[k] && is_blue && blue_w_q[k] != 8'hFF)
                            blue_w_q[k] <= blue_w_q[k] + 8'd1;
                    end
                end
                DECIDE_COLOR: begin
                    win_q <= win_d;
                    wt_q  <= (win_d == 2'd1) ? red_w_q[0] : (win_d == 2'd2) ? blue_w_q[0] : 8'd0;
                    wm_q  <= (win_d == 2'd1) ? red_w_q[1] : (win_d == 2'd2) ? blue_w_q[1] : 8'd0;
                    wb_q  <= (win_d == 2'd1) ? red_w_q[2] : (win_d == 2'd2) ? blue_w_q[2] : 8'd0;
                end
                DECIDE_SHAPE: begin
                    color_q    <= win_q;
                    shape_q    <= shape_d;
                    red_cnt_q  <= red_acc_q;
                    blue_cnt_q <= blue_acc_q;
                    valid_q    <= 1'b1;
                end
                default: begin
                    valid_q    <= 1'b0;
                    red_acc_q  <= '0;
                    blue_acc_q <= '0;
                    red_w_q    <= '0;
                    blue_w_q   <= '0;
                end
            endcase
        end
    end

    assign cam.COLOR        = color_q;
    assign cam.SHAPE        = shape_q;
    assign cam.RESULT_VALID = valid_q;
    assign cam.RED_COUNT    = red_cnt_q;
    assign cam.BLUE_COUNT   = blue_cnt_q;
endmodule
